// File: rtl/logic_gate_pkg.sv
// Shared operation codes, mode codes and FSM state encoding for the logic gate unit.
package logic_gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam logic MODE_PAIR   = 1'b0;
  localparam logic MODE_REDUCE = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/logic_gate_unit_op.sv
// Combinational bitwise operator y = f(p, q) selected by a 3-bit op code.
module logic_op
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = p;
    case (op)
      OP_AND:  y = p & q;
      OP_OR:   y = p | q;
      OP_XOR:  y = p ^ q;
      OP_NAND: y = ~(p & q);
      OP_NOR:  y = ~(p | q);
      OP_XNOR: y = ~(p ^ q);
      OP_NOT:  y = ~p;
      OP_PASS: y = p;
      default: y = p;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit: pairwise A op B per beat, or reduce mode folding a
// LAST-terminated frame of A words into one result, with valid/ready on both sides.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             MODE,
  input  logic             LAST,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic             Z,
  output logic [CNT_W-1:0] COUNT,
  output state_t           state_dbg
);

  // Handshake: a beat transfers when in_valid && in_ready, a result when
  // out_valid && out_ready; both may happen on the same edge with no bubble.
  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] pair_y;
  logic [WIDTH-1:0] red_y;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             consume;

  logic_op #(.WIDTH(WIDTH)) u_pair_op (
    .p  (A),
    .q  (B),
    .op (OP),
    .y  (pair_y)
  );

  logic_op #(.WIDTH(WIDTH)) u_red_op (
    .p  (acc_q),
    .q  (A),
    .op (op_q),
    .y  (red_y)
  );

  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = ov_q && out_ready;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    x_d     = x_q;
    z_d     = z_q;
    count_d = count_q;

    if (consume) ov_d = 1'b0;

    if (accept) begin
      if (state_q == IDLE) begin
        if (MODE == MODE_PAIR) begin
          x_d     = pair_y;
          z_d     = (pair_y == '0);
          count_d = CNT_W'(1);
          ov_d    = 1'b1;
        end else begin
          op_d  = OP;
          acc_d = A;
          cnt_d = CNT_W'(1);
          if (LAST) begin
            x_d     = A;
            z_d     = (A == '0);
            count_d = CNT_W'(1);
            ov_d    = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end else begin
        // OP/MODE on later beats are ignored; the op latched on the first beat applies.
        acc_d = red_y;
        cnt_d = cnt_inc;
        if (LAST) begin
          x_d     = red_y;
          z_d     = (red_y == '0);
          count_d = cnt_inc;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_AND;
      acc_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      x_q     <= '0;
      z_q     <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      x_q     <= x_d;
      z_q     <= z_d;
      count_q <= count_d;
    end
  end

  assign out_valid = ov_q;
  assign X         = x_q;
  assign Z         = z_q;
  assign COUNT     = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: directed scenarios plus randomized frames, checked against
// a truth-table reference model; a second instance with CNT_W=2 exercises saturation.
module tb_logic_gate_unit;
  import logic_gate_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] A, B;
  logic [2:0]   OP;
  logic         MODE, LAST;
  logic         out_ready;

  logic         in_ready, out_valid, Z;
  logic [W-1:0] X;
  logic [7:0]   COUNT;
  state_t       state_dbg;

  logic         in_ready2, out_valid2, Z2;
  logic [W-1:0] X2;
  logic [1:0]   COUNT2;
  state_t       state_dbg2;

  int total = 0;
  int bad   = 0;
  logic rand_ready = 1'b0;

  // clock / reset
  always #10 clk = ~clk;

  int rst_cnt  = 0;
  int rst_seen = 0;
  always @(negedge rst_n) rst_cnt++;

  logic_gate_unit #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .OP(OP), .MODE(MODE), .LAST(LAST),
    .out_valid(out_valid), .out_ready(out_ready),
    .X(X), .Z(Z), .COUNT(COUNT), .state_dbg(state_dbg)
  );

  logic_gate_unit #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .A(A), .B(B), .OP(OP), .MODE(MODE), .LAST(LAST),
    .out_valid(out_valid2), .out_ready(out_ready),
    .X(X2), .Z(Z2), .COUNT(COUNT2), .state_dbg(state_dbg2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: each op is a 2-input truth table applied bit by bit
  function automatic logic [W-1:0] ref_f(input logic [W-1:0] p, input logic [W-1:0] q,
                                         input logic [2:0] op);
    logic [3:0] tt;
    logic [W-1:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{p[i], q[i]}];
    return r;
  endfunction

  function automatic int sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           expc_q[$];
  logic         m_inframe = 1'b0;
  logic [2:0]   m_op = 3'd0;
  logic [W-1:0] m_acc = '0;
  int           m_cnt = 0;

  always @(negedge clk) begin
    logic mv, consume, accept;
    logic [W-1:0] r;
    if (!rst_n || rst_seen != rst_cnt) begin
      rst_seen = rst_cnt;
      exp_q.delete();
      expc_q.delete();
      m_inframe = 1'b0;
      m_acc = '0;
      m_cnt = 0;
    end
    mv = (exp_q.size() != 0);
    check_eq("out_valid", out_valid, mv);
    check_eq("out_valid2", out_valid2, mv);
    check_eq("in_ready", in_ready, !mv || out_ready);
    check_eq("in_ready2", in_ready2, !mv || out_ready);
    check_eq("state", state_dbg, m_inframe ? ACCUM : IDLE);
    check_eq("state2", state_dbg2, m_inframe ? ACCUM : IDLE);
    if (mv) begin
      check_eq("X", X, exp_q[0]);
      check_eq("X2", X2, exp_q[0]);
      check_eq("Z", Z, exp_q[0] == '0);
      check_eq("Z2", Z2, exp_q[0] == '0);
      check_eq("COUNT", COUNT, sat(expc_q[0], 255));
      check_eq("COUNT2", COUNT2, sat(expc_q[0], 3));
    end
    if (rst_n) begin
      consume = mv && out_ready;
      accept  = in_valid && (!mv || out_ready);
      if (consume) begin
        void'(exp_q.pop_front());
        void'(expc_q.pop_front());
      end
      if (accept) begin
        if (!m_inframe) begin
          if (!MODE) begin
            exp_q.push_back(ref_f(A, B, OP));
            expc_q.push_back(1);
          end else begin
            m_op = OP;
            m_acc = A;
            m_cnt = 1;
            if (LAST) begin
              exp_q.push_back(A);
              expc_q.push_back(1);
            end else begin
              m_inframe = 1'b1;
            end
          end
        end else begin
          r = ref_f(m_acc, A, m_op);
          m_acc = r;
          m_cnt++;
          if (LAST) begin
            exp_q.push_back(r);
            expc_q.push_back(m_cnt);
            m_inframe = 1'b0;
          end
        end
      end
    end
  end

  // driver tasks: all start and end at posedge+2
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                           input logic mode, input logic last);
    logic done;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1; A = a; B = b; OP = op; MODE = mode; LAST = last;
    while (!done && n < 100) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    in_valid = 1'b0;
    check_eq("accept", done, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int len;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; OP = 3'd0; MODE = 1'b0; LAST = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_X", X, 8'h00);
    check_eq("rst_Z", Z, 1'b1);
    check_eq("rst_COUNT", COUNT, 8'd0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    idle(1);

    // pairwise
    send_beat(8'hF0, 8'h3C, OP_AND, MODE_PAIR, 1'b0);
    check_eq("and_valid", out_valid, 1'b1);
    check_eq("and_X", X, 8'h30);
    check_eq("and_Z", Z, 1'b0);
    check_eq("and_COUNT", COUNT, 8'd1);
    send_beat(8'hA5, 8'hA5, OP_XOR, MODE_PAIR, 1'b0);
    check_eq("xor_X", X, 8'h00);
    check_eq("xor_Z", Z, 1'b1);
    idle(2);

    // reduce with OP change mid-frame
    send_beat(8'h01, 8'h00, OP_OR, MODE_REDUCE, 1'b0);
    check_eq("red_no_out1", out_valid, 1'b0);
    send_beat(8'h02, 8'h00, OP_AND, MODE_REDUCE, 1'b0);
    check_eq("red_no_out2", out_valid, 1'b0);
    send_beat(8'h84, 8'h00, OP_AND, MODE_PAIR, 1'b1);
    check_eq("red_valid", out_valid, 1'b1);
    check_eq("red_X", X, 8'h87);
    check_eq("red_COUNT", COUNT, 8'd3);
    idle(2);

    // backpressure
    out_ready = 1'b0;
    send_beat(8'h0F, 8'h30, OP_OR, MODE_PAIR, 1'b0);
    in_valid = 1'b1; A = 8'hFF; B = 8'h55; OP = OP_AND; MODE = MODE_PAIR; LAST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_X", X, 8'h3F);
      check_eq("bp_COUNT", COUNT, 8'd1);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check_eq("bp_next_valid", out_valid, 1'b1);
    check_eq("bp_next_X", X, 8'h55);
    idle(2);

    // reset mid-frame
    send_beat(8'h11, 8'h00, OP_OR, MODE_REDUCE, 1'b0);
    send_beat(8'h22, 8'h00, OP_OR, MODE_REDUCE, 1'b0);
    check_eq("mid_state", state_dbg, ACCUM);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_state", state_dbg, IDLE);
    check_eq("mid_rst_COUNT", COUNT, 8'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    send_beat(8'hFF, 8'h00, OP_AND, MODE_REDUCE, 1'b1);
    check_eq("post_rst_X", X, 8'hFF);
    check_eq("post_rst_COUNT", COUNT, 8'd1);
    idle(2);

    // counter saturation
    for (int k = 0; k < 5; k++) send_beat(8'h01, 8'h00, OP_XOR, MODE_REDUCE, k == 4);
    check_eq("sat_X", X, 8'h01);
    check_eq("sat_COUNT", COUNT, 8'd5);
    check_eq("sat_COUNT2", COUNT2, 2'd3);
    idle(2);

    // randomized frames with random backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        send_beat(W'($urandom), W'($urandom), 3'($urandom), MODE_PAIR, 1'($urandom));
      end else begin
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++)
          send_beat(W'($urandom), W'($urandom), 3'($urandom),
                    (k == 0) ? MODE_REDUCE : 1'($urandom), k == len - 1);
      end
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check_eq("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
